alu_instr_fetch: RTL

Instruction fetch/issue stage that sits directly upstream of the ALU and drives its 16-bit instruction bus. Holds a program in a local instruction memory and, after a start pulse, fetches sequentially from address 0. Presents instructions through a valid/ready handshake with a small prefetch queue, and stops on a HALT opcode or at end of memory. Instruction format: [15:12] opcode, [11:8] rA, [7:4] rB, [3:0] rD (LDI: [11:8] dest, [7:0] imm).

---
 rtl/alu_isa_pkg.sv | 36 +++
 rtl/alu_instr_fetch_queue.sv | 59 +++++
 rtl/alu_instr_fetch.sv | 120 ++++++++++++
 3 files changed

// File: rtl/alu_isa_pkg.sv
// Shared ISA definitions for the ALU front end: opcodes, instruction layout
// and the fetch-stage state encoding.
package alu_isa_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_NOT  = 4'd6,
    OP_HALT = 4'd14,
    OP_LDI  = 4'd15
  } opcode_e;

  // LDI reuses {ra} as destination and {rb, rd} as the 8-bit immediate.
  typedef struct packed {
    opcode_e    opcode;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rd;
  } instr_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    HALT
  } fetch_state_e;

  function automatic logic is_halt(input logic [3:0] op);
    return op == 4'(OP_HALT);
  endfunction

endpackage

// File: rtl/alu_instr_fetch_queue.sv
// Small prefetch FIFO between instruction memory and the ALU. Head is visible
// combinationally; a push into an empty queue shows up on the next cycle.
module instr_queue #(
  parameter int QDEPTH  = 4,
  parameter int INSTR_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push_i,
  input  logic [INSTR_W-1:0]        data_i,
  input  logic                      pop_i,
  output logic [INSTR_W-1:0]        head_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [$clog2(QDEPTH):0]   count_o
);
  localparam int PW = $clog2(QDEPTH);

  logic [INSTR_W-1:0] slots [QDEPTH];
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PW:0]        count_q, count_d;
  logic               do_push, do_pop;

  assign full_o  = (count_q == (PW+1)'(QDEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = slots[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + (PW+1)'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - (PW+1)'(1);
    end
  end

  // Storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      slots[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/alu_instr_fetch.sv
// Instruction fetch/issue stage: local program memory, credit-limited
// prefetch into a small queue, and a run FSM that stops on HALT or end of memory.
module alu_instr_fetch
  import alu_isa_pkg::*;
#(
  parameter int IMEM_DEPTH = 64,
  parameter int QDEPTH     = 4,
  parameter int INSTR_W    = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          prog_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
  input  logic [INSTR_W-1:0]            prog_data,
  input  logic                          start,
  output logic [INSTR_W-1:0]            instr,
  output logic                          instr_valid,
  input  logic                          instr_ready,
  output logic                          busy,
  output logic                          halted,
  output logic [$clog2(IMEM_DEPTH)-1:0] pc
);
  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int CW = $clog2(QDEPTH) + 1;

  logic [INSTR_W-1:0] imem [IMEM_DEPTH];
  logic [INSTR_W-1:0] rd_data_q;
  logic               rd_valid_q;
  fetch_state_e       state_q;
  logic [AW-1:0]      pc_q, pc_d, rd_addr, last_addr;
  logic               busy_q, halted_q;

  logic               start_ok, we_ok, pop, push, halt_ret, issue_run, issue;
  logic               q_full, q_empty;
  logic [CW-1:0]      q_count;
  logic [INSTR_W-1:0] q_head;
  logic [CW:0]        credit_use;

  assign start_ok  = start && !busy_q;
  assign we_ok     = prog_we && !busy_q;
  assign last_addr = AW'(IMEM_DEPTH - 1);

  assign halt_ret  = rd_valid_q && is_halt(rd_data_q[INSTR_W-1 -: 4]);
  assign pop       = !q_empty && instr_ready;
  assign push      = rd_valid_q && !halt_ret && (!q_full || pop);

  // Slots already queued or promised by an outstanding read, net of this cycle's pop.
  assign credit_use = {1'b0, q_count} + (CW+1)'(rd_valid_q) - (CW+1)'(pop);
  assign issue_run  = (state_q == RUN) && !halt_ret && (credit_use < (CW+1)'(QDEPTH));
  assign issue      = start_ok || issue_run;
  assign rd_addr    = start_ok ? '0 : pc_q;
  assign pc_d       = (rd_addr == last_addr) ? rd_addr : rd_addr + AW'(1);

  // A write landing on the address being read forwards the new word.
  always_ff @(posedge clk) begin
    if (we_ok) begin
      imem[prog_addr] <= prog_data;
    end
    if (issue) begin
      rd_data_q <= (we_ok && (prog_addr == rd_addr)) ? prog_data : imem[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= issue;
      if (issue) pc_q <= pc_d;
      case (state_q)
        IDLE, HALT: begin
          if (start_ok) begin
            state_q  <= RUN;
            busy_q   <= 1'b1;
            halted_q <= 1'b0;
          end
        end
        RUN: begin
          if (halt_ret || (issue_run && (pc_q == last_addr))) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (q_empty && !rd_valid_q) begin
            state_q  <= HALT;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  instr_queue #(
    .QDEPTH  (QDEPTH),
    .INSTR_W (INSTR_W)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (rd_data_q),
    .pop_i   (pop),
    .head_o  (q_head),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_count)
  );

  assign instr       = q_empty ? '0 : q_head;
  assign instr_valid = !q_empty;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign pc          = pc_q;

endmodule
